plb_dac_stream: RTL
===================

Name: plb_dac_stream

Overview:
Multi-channel DAC sample engine. It is the parametrised successor to the single-channel PLB DAC peripheral and sits between the PLB slave user-logic register file and the DAC pins. Each channel has its own sample FIFO, written by software through a simple write port. A programmable rate divider paces sample frames, and each frame is time-multiplexed onto one DAC data bus with a word strobe and a channel select. Two modes: STREAM consumes the FIFO; LOOP replays the FIFO contents circularly as a waveform table.

Parameters:
DAC_WIDTH, 10, sample width in bits
NUM_CH, 2, channel count (1..8)
FIFO_DEPTH, 16, entries per channel FIFO; power of two, minimum 4
RATE_WIDTH, 16, width of the rate divider
CH_W, clog2(NUM_CH) with a minimum of 1, localparam, channel index width
LVL_W, clog2(FIFO_DEPTH)+1, localparam, level width

Ports:
SPLB_Clk  in  1  single clock for the whole block
SPLB_Rst_n  in  1  reset, asynchronous, active-low
Ctrl_Enable  in  1  level signal: 1 = run, 0 = stop after the current frame
Ctrl_Mode  in  1  0 = STREAM, 1 = LOOP; sampled on the ARM->RUN transition
Ctrl_RateDiv  in  RATE_WIDTH  frame period minus 1, in clocks
Ctrl_Flush  in  1  single-cycle pulse; empties all FIFOs
Wr_En  in  1  sample write strobe
Wr_Ch  in  CH_W  target channel of the write
Wr_Data  in  DAC_WIDTH  sample to write
Wr_Full  out  NUM_CH  per-channel FIFO full flag
Stat_Level  out  NUM_CH*LVL_W  per-channel fill level, channel 0 in the LSBs
Stat_Underrun  out  NUM_CH  sticky per-channel underrun flag
Stat_Clr  in  1  single-cycle pulse; clears Stat_Underrun
Stat_Running  out  1  1 while the FSM is in RUN or STOP
S_Data  out  DAC_WIDTH  DAC data bus, registered
S_ChSel  out  CH_W  channel index of S_Data
S_DCLKIO  out  1  word strobe, high one cycle per valid S_Data word
S_PWRDN  out  1  DAC power-down
S_OpEn  out  NUM_CH  per-channel output enable

Behaviour:
- Reset (asynchronous, SPLB_Rst_n=0):
  - FSM goes to IDLE; all pointers, levels, counters and flags are cleared.
  - S_Data=0, S_ChSel=0, S_DCLKIO=0, S_PWRDN=1, S_OpEn=0, Wr_Full=0, Stat_Underrun=0, Stat_Running=0.
  - Reset in the middle of a frame aborts the frame immediately.
- FIFO write:
  - Wr_En with Wr_Ch<NUM_CH and that channel not full writes the sample and increments its level on the next clock.
  - A write to a full channel, or with Wr_Ch>=NUM_CH, is dropped with no state change.
  - Full is judged on the registered level, so a write to a full channel is dropped even if a read occurs in the same cycle.
  - A simultaneous write and read on the same channel leaves the level unchanged.
- FSM states: IDLE, ARM, RUN, STOP.
  - IDLE: S_PWRDN=1, S_OpEn=0. Ctrl_Flush is honoured only here and clears all pointers and levels on the next clock. Ctrl_Enable=1 -> ARM.
  - ARM: S_PWRDN=0. When every channel has level>=1, latch Ctrl_Mode and go to RUN; the rate counter loads Ctrl_RateDiv. Ctrl_Enable=0 -> IDLE.
  - RUN: S_OpEn=all ones. The rate counter decrements each clock; at 0 it issues a frame tick and reloads. Ctrl_Enable=0 -> STOP.
  - STOP: completes the frame in progress, or goes straight to IDLE if no frame is in progress. S_OpEn stays all ones until the transition to IDLE.
- Effective period: max(Ctrl_RateDiv, NUM_CH-1)+1 clocks.
- Frame sequencing: if the tick occurs in cycle t, channel k is emitted in cycle t+1+k with S_Data=sample, S_ChSel=k, S_DCLKIO=1. S_DCLKIO=0 on all other cycles, and S_Data holds its last value.
- STREAM mode:
  - The slot pops the head entry of the channel FIFO.
  - If the channel is empty at its slot, the last value emitted for that channel (0 after reset or flush) is repeated, Stat_Underrun[k] is set, and the FSM stays in RUN.
- LOOP mode:
  - Entries are not consumed and the level is unchanged.
  - A play pointer starts at the read pointer and advances on each slot, wrapping to the read pointer when it reaches the write pointer.
  - Writes during LOOP extend the loop.
- Stat_Clr and a new underrun in the same cycle: set wins.
- Ctrl_Mode changes outside the ARM->RUN transition are ignored until the next ARM.

Test Plan:
- Reset, then write ch0: 0x001,0x002 and ch1: 0x3FF,0x200; RateDiv=3; Enable=1 -> S_DCLKIO strobes (ch0,0x001),(ch1,0x3FF), then 4 clocks later (ch0,0x002),(ch1,0x200). Then a frame repeating those last values with Stat_Underrun=2'b11.
- LOOP mode with ch0 loaded with 3 samples A,B,C (ch1 1 sample) -> ch0 emits A,B,C,A,B,C over successive frames; Stat_Level for ch0 stays 3 and no underrun is flagged.
- Write 17 samples to ch0 with FIFO_DEPTH=16 -> Wr_Full[0]=1 after the 16th write; the 17th is dropped and the level stays 16. Simultaneous read and write while full -> level 15, write dropped.
- RateDiv=0 with NUM_CH=2 -> frame period is 2 clocks (clamped); S_DCLKIO is high continuously and S_ChSel alternates 0,1.
- Enable drops during the slot for ch0 -> ch1 is still emitted, then IDLE with S_PWRDN=1 and S_OpEn=0. Ctrl_Flush in RUN is ignored; in IDLE it zeroes all levels.
- Assert SPLB_Rst_n low mid-frame -> all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/plb_dac_stream_if.sv
// Control, sample-write, status and DAC-pin bundle of the multi-channel DAC sample engine.
// master = register-file side, slave = the engine itself.
interface plb_dac_stream_if #(
    parameter int unsigned DAC_WIDTH  = 10,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RATE_WIDTH = 16
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                    Ctrl_Enable;
    logic                    Ctrl_Mode;
    logic [RATE_WIDTH-1:0]   Ctrl_RateDiv;
    logic                    Ctrl_Flush;
    logic                    Wr_En;
    logic [CH_W-1:0]         Wr_Ch;
    logic [DAC_WIDTH-1:0]    Wr_Data;
    logic [NUM_CH-1:0]       Wr_Full;
    logic [NUM_CH*LVL_W-1:0] Stat_Level;
    logic [NUM_CH-1:0]       Stat_Underrun;
    logic                    Stat_Clr;
    logic                    Stat_Running;
    logic [DAC_WIDTH-1:0]    S_Data;
    logic [CH_W-1:0]         S_ChSel;
    logic                    S_DCLKIO;
    logic                    S_PWRDN;
    logic [NUM_CH-1:0]       S_OpEn;

    modport master (
        output Ctrl_Enable, Ctrl_Mode, Ctrl_RateDiv, Ctrl_Flush,
        output Wr_En, Wr_Ch, Wr_Data, Stat_Clr,
        input  Wr_Full, Stat_Level, Stat_Underrun, Stat_Running,
        input  S_Data, S_ChSel, S_DCLKIO, S_PWRDN, S_OpEn
    );

    modport slave (
        input  Ctrl_Enable, Ctrl_Mode, Ctrl_RateDiv, Ctrl_Flush,
        input  Wr_En, Wr_Ch, Wr_Data, Stat_Clr,
        output Wr_Full, Stat_Level, Stat_Underrun, Stat_Running,
        output S_Data, S_ChSel, S_DCLKIO, S_PWRDN, S_OpEn
    );
endinterface

// File: rtl/plb_dac_stream.sv
// Multi-channel DAC sample engine: per-channel sample FIFOs, rate-paced frames, and
// time-multiplexed output onto one DAC bus in STREAM (consume) or LOOP (replay) mode.
module plb_dac_stream #(
    parameter int unsigned DAC_WIDTH  = 10,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RATE_WIDTH = 16
) (
    input  logic            SPLB_Clk,
    input  logic            SPLB_Rst_n,
    plb_dac_stream_if.slave io_plb
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StStop} state_e;

    state_e                r_state, w_state_nxt;
    logic                  r_mode, w_mode_nxt;
    logic [RATE_WIDTH-1:0] r_cnt, w_cnt_nxt, w_reload;
    logic                  r_busy, w_busy_nxt;
    logic [CH_W-1:0]       r_slot, w_slot_nxt;
    logic                  w_tick, w_flush, w_start, w_go;
    logic [CH_W-1:0]       w_ch;

    logic [DAC_WIDTH-1:0] r_mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr [NUM_CH];
    logic [PTR_W-1:0]     r_rptr [NUM_CH];
    logic [PTR_W-1:0]     r_pptr [NUM_CH];
    logic [PTR_W-1:0]     w_wptr_nxt [NUM_CH];
    logic [PTR_W-1:0]     w_rptr_nxt [NUM_CH];
    logic [PTR_W-1:0]     w_pptr_nxt [NUM_CH];
    logic [PTR_W-1:0]     w_pnext [NUM_CH];
    logic [LVL_W-1:0]     r_level [NUM_CH];
    logic [LVL_W-1:0]     w_level_nxt [NUM_CH];
    logic [DAC_WIDTH-1:0] r_last [NUM_CH];
    logic [DAC_WIDTH-1:0] w_last_nxt [NUM_CH];

    logic [NUM_CH-1:0]       r_underrun, w_underrun_nxt, w_ur_set;
    logic [NUM_CH-1:0]       w_wr_sel, w_pop, w_ready, w_full;
    logic [NUM_CH*LVL_W-1:0] w_level_flat;

    logic [DAC_WIDTH-1:0] r_sdata, w_sdata_nxt;
    logic [CH_W-1:0]      r_chsel;
    logic                 r_dclk;

    // Period is clamped so a frame's slots never overlap the next tick.
    assign w_reload = (io_plb.Ctrl_RateDiv < RATE_WIDTH'(NUM_CH - 1)) ?
                      RATE_WIDTH'(NUM_CH - 1) : io_plb.Ctrl_RateDiv;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_ready[c] = (r_level[c] != '0);
            w_full[c]  = (r_level[c] == FULL_LVL);
            w_level_flat[c*LVL_W +: LVL_W] = r_level[c];
            w_wr_sel[c] = io_plb.Wr_En && !w_flush && (io_plb.Wr_Ch == CH_W'(c)) &&
                          !w_full[c];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_tick      = 1'b0;
        w_flush     = 1'b0;
        w_start     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_flush = io_plb.Ctrl_Flush;
                if (io_plb.Ctrl_Enable) w_state_nxt = StArm;
            end
            StArm: begin
                if (!io_plb.Ctrl_Enable) begin
                    w_state_nxt = StIdle;
                end else if (&w_ready) begin
                    w_state_nxt = StRun;
                    w_start     = 1'b1;
                    w_mode_nxt  = io_plb.Ctrl_Mode;
                    w_cnt_nxt   = w_reload;
                end
            end
            StRun: begin
                if (r_cnt == '0) begin
                    w_tick    = 1'b1;
                    w_cnt_nxt = w_reload;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                if (!io_plb.Ctrl_Enable) w_state_nxt = StStop;
            end
            StStop: begin
                if (!r_busy || (r_slot == LAST_CH)) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Slot 0 is served in the tick cycle itself; the remaining slots follow back to back.
    always_comb begin
        w_go       = w_tick || r_busy;
        w_ch       = r_busy ? r_slot : '0;
        w_busy_nxt = w_go && (w_ch != LAST_CH);
        w_slot_nxt = w_ch + 1'b1;
    end

    always_comb begin
        w_sdata_nxt = r_sdata;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_pptr_nxt  = r_pptr;
        w_level_nxt = r_level;
        w_last_nxt  = r_last;
        w_pop       = '0;
        w_ur_set    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pnext[c] = r_pptr[c] + 1'b1;
            if (w_flush) begin
                w_wptr_nxt[c]  = '0;
                w_rptr_nxt[c]  = '0;
                w_pptr_nxt[c]  = '0;
                w_level_nxt[c] = '0;
                w_last_nxt[c]  = '0;
            end else begin
                if (w_wr_sel[c]) w_wptr_nxt[c] = r_wptr[c] + 1'b1;
                if (w_start) w_pptr_nxt[c] = r_rptr[c];
                if (w_go && (w_ch == CH_W'(c))) begin
                    if (r_level[c] == '0) begin
                        w_sdata_nxt = r_last[c];
                        w_ur_set[c] = 1'b1;
                    end else if (r_mode) begin
                        w_sdata_nxt   = r_mem[c][r_pptr[c]];
                        w_last_nxt[c] = r_mem[c][r_pptr[c]];
                        // Play pointer wraps at the write pointer, so new writes extend the loop.
                        w_pptr_nxt[c] = (w_pnext[c] == r_wptr[c]) ? r_rptr[c] : w_pnext[c];
                    end else begin
                        w_sdata_nxt   = r_mem[c][r_rptr[c]];
                        w_last_nxt[c] = r_mem[c][r_rptr[c]];
                        w_rptr_nxt[c] = r_rptr[c] + 1'b1;
                        w_pop[c]      = 1'b1;
                    end
                end
                w_level_nxt[c] = r_level[c] + LVL_W'(w_wr_sel[c]) - LVL_W'(w_pop[c]);
            end
        end
        w_underrun_nxt = (io_plb.Stat_Clr ? '0 : r_underrun) | w_ur_set;
    end

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            r_state    <= StIdle;
            r_mode     <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_slot     <= '0;
            r_underrun <= '0;
            r_sdata    <= '0;
            r_chsel    <= '0;
            r_dclk     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_pptr[c]  <= '0;
                r_level[c] <= '0;
                r_last[c]  <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_slot     <= w_slot_nxt;
            r_underrun <= w_underrun_nxt;
            r_sdata    <= w_sdata_nxt;
            r_dclk     <= w_go;
            if (w_go) r_chsel <= w_ch;
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_pptr  <= w_pptr_nxt;
            r_level <= w_level_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge SPLB_Clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_sel[c]) r_mem[c][r_wptr[c]] <= io_plb.Wr_Data;
        end
    end

    assign io_plb.Wr_Full       = w_full;
    assign io_plb.Stat_Level    = w_level_flat;
    assign io_plb.Stat_Underrun = r_underrun;
    assign io_plb.Stat_Running  = (r_state == StRun) || (r_state == StStop);
    assign io_plb.S_Data        = r_sdata;
    assign io_plb.S_ChSel       = r_chsel;
    assign io_plb.S_DCLKIO      = r_dclk;
    assign io_plb.S_PWRDN       = (r_state == StIdle);
    assign io_plb.S_OpEn        = io_plb.Stat_Running ? '1 : '0;
endmodule
